// File: rtl/addsub_acc_pkg.sv
// Shared op codes and widths for the add/subtract/accumulate unit.
package addsub_acc_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ACC = 2'd2,
        CLR = 2'd3
    } op_e;

endpackage

// File: rtl/addsub_acc_core.sv
// Combinational datapath: computes result, accumulator update and signed overflow.
// Saturating arithmetic is selected by defining ADDSUB_ACC_SAT_EN; otherwise results wrap.
module addsub_acc_core
    import addsub_acc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              op,
    input  logic             ch_ok,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] acc_next,
    output logic             acc_we,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   sum_ext;
    logic             ovf_raw;
    logic [WIDTH-1:0] val;

    assign a_ext   = {a[WIDTH-1], a};
    assign b_ext   = {b[WIDTH-1], b};
    assign acc_ext = {acc[WIDTH-1], acc};

    always_comb begin
        sum_ext = '0;
        case (op)
            ADD:     sum_ext = a_ext + b_ext;
            SUB:     sum_ext = a_ext - b_ext;
            ACC:     sum_ext = acc_ext + a_ext;
            default: sum_ext = '0;
        endcase
    end

    // The WIDTH+1 result is out of range exactly when its top two bits disagree.
    assign ovf_raw = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];

`ifdef ADDSUB_ACC_SAT_EN
    assign val = ovf_raw ? (sum_ext[WIDTH] ? SAT_MIN : SAT_MAX) : sum_ext[WIDTH-1:0];
`else
    assign val = sum_ext[WIDTH-1:0];
`endif

    always_comb begin
        res      = '0;
        acc_next = '0;
        acc_we   = 1'b0;
        ovf      = 1'b0;
        case (op)
            ADD, SUB: begin
                res = val;
                ovf = ovf_raw;
            end
            ACC: begin
                if (ch_ok) begin
                    res      = val;
                    acc_next = val;
                    acc_we   = 1'b1;
                    ovf      = ovf_raw;
                end
            end
            default: begin
                // Read-and-clear: return the old value, never flag overflow.
                if (ch_ok) begin
                    res      = acc;
                    acc_next = '0;
                    acc_we   = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/addsub_acc_unit.sv
// Handshaked add/sub/accumulate unit with one signed accumulator per channel.
// Optional saturation via ADDSUB_ACC_SAT_EN (handled inside addsub_acc_core).
module addsub_acc_unit
    import addsub_acc_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_CH  = 4,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [OP_W-1:0]  i_op,
    input  logic [CH_W-1:0]  i_ch,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CH_W-1:0]  o_ch,
    output logic [WIDTH-1:0] o_res,
    output logic             o_ovf
);

    logic [WIDTH-1:0] acc_reg [N_CH];
    logic [N_CH-1:0]  ch_hit;
    logic             ch_ok;
    logic [WIDTH-1:0] acc_rd;
    logic [WIDTH-1:0] core_res;
    logic [WIDTH-1:0] core_acc_next;
    logic             core_acc_we;
    logic             core_ovf;
    logic             accept;

    logic             valid_reg;
    logic [CH_W-1:0]  ch_reg;
    logic [WIDTH-1:0] res_reg;
    logic             ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_hit
            assign ch_hit[gi] = (i_ch == CH_W'(gi));
        end
    endgenerate

    // No bit set means an index beyond N_CH (non-power-of-two channel counts).
    assign ch_ok = |ch_hit;

    always_comb begin
        acc_rd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_hit[i]) acc_rd = acc_reg[i];
        end
    end

    addsub_acc_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op       (op_e'(i_op)),
        .ch_ok    (ch_ok),
        .a        (i_a),
        .b        (i_b),
        .acc      (acc_rd),
        .res      (core_res),
        .acc_next (core_acc_next),
        .acc_we   (core_acc_we),
        .ovf      (core_ovf)
    );

    assign o_ready = !valid_reg || i_ready;
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_CH; i++) acc_reg[i] <= '0;
        end else if (accept && core_acc_we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_hit[i]) acc_reg[i] <= core_acc_next;
            end
        end
    end

    // Accept is only possible when the register is empty or draining, so a
    // plain load covers both the EMPTY->FULL and FULL->FULL cases.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg <= 1'b0;
            ch_reg    <= '0;
            res_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            ch_reg    <= i_ch;
            res_reg   <= core_res;
            ovf_reg   <= core_ovf;
        end else if (i_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign o_valid = valid_reg;
    assign o_ch    = ch_reg;
    assign o_res   = res_reg;
    assign o_ovf   = ovf_reg;

endmodule

// File: tb/tb_addsub_acc_unit.sv
// Directed bench for addsub_acc_unit: WIDTH=8 with 4 channels and with 3 channels.
// Expected values follow ADDSUB_ACC_SAT_EN when it is defined for the build.
module tb_addsub_acc_unit;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_ACC = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       valid0 = 1'b0, ready0 = 1'b1;
    logic [1:0] op0 = '0, ch0 = '0;
    logic [7:0] a0 = '0, b0 = '0;
    logic       o_ready0, o_valid0, o_ovf0;
    logic [1:0] o_ch0;
    logic [7:0] o_res0;

    logic       valid1 = 1'b0, ready1 = 1'b1;
    logic [1:0] op1 = '0, ch1 = '0;
    logic [7:0] a1 = '0, b1 = '0;
    logic       o_ready1, o_valid1, o_ovf1;
    logic [1:0] o_ch1;
    logic [7:0] o_res1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_acc_unit #(.WIDTH(8), .N_CH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid0), .o_ready(o_ready0),
        .i_op(op0), .i_ch(ch0), .i_a(a0), .i_b(b0), .o_valid(o_valid0),
        .i_ready(ready0), .o_ch(o_ch0), .o_res(o_res0), .o_ovf(o_ovf0)
    );

    addsub_acc_unit #(.WIDTH(8), .N_CH(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(o_ready1),
        .i_op(op1), .i_ch(ch1), .i_a(a1), .i_b(b1), .o_valid(o_valid1),
        .i_ready(ready1), .o_ch(o_ch1), .o_res(o_res1), .o_ovf(o_ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step0(input logic [1:0] op, input logic [1:0] ch,
                         input logic [7:0] a, input logic [7:0] b);
        op0 = op; ch0 = ch; a0 = a; b0 = b; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        $display("dut4 op=%0d ch=%0d a=0x%0h b=0x%0h -> valid=%0b ch=%0d res=0x%0h ovf=%0b",
                 op, ch, a, b, o_valid0, o_ch0, o_res0, o_ovf0);
    endtask

    task automatic step1(input logic [1:0] op, input logic [1:0] ch,
                         input logic [7:0] a, input logic [7:0] b);
        op1 = op; ch1 = ch; a1 = a; b1 = b; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        $display("dut3 op=%0d ch=%0d a=0x%0h b=0x%0h -> valid=%0b ch=%0d res=0x%0h ovf=%0b",
                 op, ch, a, b, o_valid1, o_ch1, o_res1, o_ovf1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid", 32'(o_valid0), 32'd0);
        chk("rst_res",   32'(o_res0),   32'd0);
        chk("rst_ch",    32'(o_ch0),    32'd0);
        chk("rst_ovf",   32'(o_ovf0),   32'd0);
        chk("rst_ready", 32'(o_ready0), 32'd1);

        step0(OP_ADD, 2'd1, 8'd5, 8'd3);
        chk("add_valid", 32'(o_valid0), 32'd1);
        chk("add_res",   32'(o_res0),   32'h08);
        chk("add_ovf",   32'(o_ovf0),   32'd0);
        chk("add_ch",    32'(o_ch0),    32'd1);
        step0(OP_SUB, 2'd0, 8'd3, 8'd5);
        chk("sub_res",   32'(o_res0),   32'hFE);
        chk("sub_ovf",   32'(o_ovf0),   32'd0);

        // Back-to-back accumulation on channel 2, then read-and-clear.
        step0(OP_ACC, 2'd2, 8'd10, 8'hAA);
        chk("acc2_1", 32'(o_res0), 32'h0A);
        step0(OP_ACC, 2'd2, 8'd20, 8'h55);
        chk("acc2_2", 32'(o_res0), 32'h1E);
        step0(OP_ACC, 2'd2, 8'hFB, 8'h00);
        chk("acc2_3", 32'(o_res0), 32'h19);
        chk("acc2_ch", 32'(o_ch0), 32'd2);
        step0(OP_CLR, 2'd2, 8'h11, 8'h22);
        chk("clr2_res", 32'(o_res0), 32'h19);
        chk("clr2_ovf", 32'(o_ovf0), 32'd0);
        step0(OP_ACC, 2'd2, 8'd1, 8'd0);
        chk("acc2_after_clr", 32'(o_res0), 32'h01);

        // Signed overflow on ADD, SUB and ACC.
        step0(OP_ADD, 2'd0, 8'd100, 8'd50);
`ifdef ADDSUB_ACC_SAT_EN
        chk("add_ovf_res", 32'(o_res0), 32'h7F);
`else
        chk("add_ovf_res", 32'(o_res0), 32'h96);
`endif
        chk("add_ovf_flag", 32'(o_ovf0), 32'd1);
        step0(OP_SUB, 2'd0, 8'h9C, 8'd50);
`ifdef ADDSUB_ACC_SAT_EN
        chk("sub_ovf_res", 32'(o_res0), 32'h80);
`else
        chk("sub_ovf_res", 32'(o_res0), 32'h6A);
`endif
        chk("sub_ovf_flag", 32'(o_ovf0), 32'd1);
        step0(OP_ACC, 2'd0, 8'd100, 8'd0);
        chk("acc0_1", 32'(o_res0), 32'h64);
        step0(OP_ACC, 2'd0, 8'd100, 8'd0);
`ifdef ADDSUB_ACC_SAT_EN
        chk("acc0_ovf_res", 32'(o_res0), 32'h7F);
`else
        chk("acc0_ovf_res", 32'(o_res0), 32'hC8);
`endif
        chk("acc0_ovf_flag", 32'(o_ovf0), 32'd1);
        step0(OP_CLR, 2'd0, 8'd0, 8'd0);
`ifdef ADDSUB_ACC_SAT_EN
        chk("clr0_stored", 32'(o_res0), 32'h7F);
`else
        chk("clr0_stored", 32'(o_res0), 32'hC8);
`endif
        chk("clr0_ovf", 32'(o_ovf0), 32'd0);

        // Backpressure: stall three cycles with an ACC waiting at the input.
        step0(OP_ACC, 2'd3, 8'd7, 8'd0);
        chk("bp_first", 32'(o_res0), 32'h07);
        ready0 = 1'b0;
        op0 = OP_ACC; ch0 = 2'd3; a0 = 8'd9; b0 = 8'd0; valid0 = 1'b1;
        #1;
        chk("bp_ready_low", 32'(o_ready0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            $display("dut4 stall %0d -> valid=%0b ready=%0b res=0x%0h", i, o_valid0, o_ready0, o_res0);
            chk("bp_hold_valid", 32'(o_valid0), 32'd1);
            chk("bp_hold_res",   32'(o_res0),   32'h07);
            chk("bp_hold_ready", 32'(o_ready0), 32'd0);
        end
        ready0 = 1'b1;
        #1;
        chk("bp_ready_release", 32'(o_ready0), 32'd1);
        @(posedge clk); #1;
        valid0 = 1'b0;
        $display("dut4 release -> valid=%0b res=0x%0h", o_valid0, o_res0);
        chk("bp_accept_res", 32'(o_res0), 32'h10);
        chk("bp_accept_valid", 32'(o_valid0), 32'd1);
        @(posedge clk); #1;
        chk("bp_drain_valid", 32'(o_valid0), 32'd0);

        // Reset with a result pending and an op at the input.
        step0(OP_ACC, 2'd1, 8'd40, 8'd0);
        chk("pre_rst_acc1", 32'(o_res0), 32'h28);
        rst = 1'b1;
        op0 = OP_ACC; ch0 = 2'd1; a0 = 8'd5; valid0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid0 = 1'b0;
        $display("dut4 reset pulse -> valid=%0b res=0x%0h", o_valid0, o_res0);
        chk("mid_rst_valid", 32'(o_valid0), 32'd0);
        chk("mid_rst_res",   32'(o_res0),   32'd0);
        step0(OP_ACC, 2'd1, 8'd1, 8'd0);
        chk("post_rst_acc1", 32'(o_res0), 32'h01);

        // Three-channel instance: index 3 is out of range.
        step1(OP_ACC, 2'd0, 8'd5, 8'd0);
        chk("n3_acc0", 32'(o_res1), 32'h05);
        step1(OP_ACC, 2'd1, 8'd6, 8'd0);
        step1(OP_ACC, 2'd2, 8'd7, 8'd0);
        chk("n3_acc2", 32'(o_res1), 32'h07);
        step1(OP_ACC, 2'd3, 8'd127, 8'd1);
        chk("n3_oor_acc_res", 32'(o_res1), 32'd0);
        chk("n3_oor_acc_ovf", 32'(o_ovf1), 32'd0);
        chk("n3_oor_acc_valid", 32'(o_valid1), 32'd1);
        step1(OP_CLR, 2'd3, 8'd0, 8'd0);
        chk("n3_oor_clr_res", 32'(o_res1), 32'd0);
        step1(OP_ADD, 2'd3, 8'd2, 8'd3);
        chk("n3_oor_add_res", 32'(o_res1), 32'h05);
        chk("n3_oor_add_ch",  32'(o_ch1),  32'd3);
        step1(OP_CLR, 2'd0, 8'd0, 8'd0);
        chk("n3_clr0", 32'(o_res1), 32'h05);
        step1(OP_CLR, 2'd1, 8'd0, 8'd0);
        chk("n3_clr1", 32'(o_res1), 32'h06);
        step1(OP_CLR, 2'd2, 8'd0, 8'd0);
        chk("n3_clr2", 32'(o_res1), 32'h07);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
